// File: rtl/sumador_arbiter.sv
// rtl/sumador_arbiter.sv - round-robin arbiter sharing one 16-bit add/subtract unit
// Optional feature macro: OVF_STICKY_EN (per-requester sticky overflow flags with clear inputs).

// Shared 17-bit unsigned add/subtract; bit 16 is carry on suma, borrow on resta.
module sumador_16bits (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        ctrl,
  output logic [16:0] sum
);

  // ctrl = 1 selects a+b, ctrl = 0 selects a-b
  always_comb begin
    sum = '0;
    if (ctrl) sum = {1'b0, a} + {1'b0, b};
    else      sum = {1'b0, a} - {1'b0, b};
  end

endmodule

module sumador_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [16*N_REQ-1:0]   op_a,
  input  logic [16*N_REQ-1:0]   op_b,
  input  logic [N_REQ-1:0]      op_ctrl,
  output logic [N_REQ-1:0]      gnt,
  output logic                  done,
  output logic [ID_W-1:0]       done_id,
  output logic [15:0]           result,
  output logic                  overflow
`ifdef OVF_STICKY_EN
  ,
  input  logic [N_REQ-1:0]      ovf_clr,
  output logic [N_REQ-1:0]      ovf_sticky
`endif
);

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

  state_t                  state;
  logic [ID_W-1:0]         ptr;
  logic [ID_W-1:0]         lat_id;
  logic [15:0]             lat_a;
  logic [15:0]             lat_b;
  logic                    lat_ctrl;
  logic [16:0]             sum;

  // Request vector padded to the full id space so it can be indexed by an id directly
  logic [(1<<ID_W)-1:0]    req_pad;
  logic [ID_W:0]           cand;
  logic [ID_W-1:0]         win;
  logic                    found;
  logic [15:0]             sel_a;
  logic [15:0]             sel_b;
  logic                    sel_ctrl;
  logic [N_REQ-1:0]        gnt_nxt;

  // Rotating-priority search: first set request at or above ptr, wrapping at N_REQ
  always_comb begin
    req_pad = '0;
    req_pad[N_REQ-1:0] = req;
    cand  = '0;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(N_REQ)) cand = cand - (ID_W+1)'(N_REQ);
      if (!found && req_pad[cand[ID_W-1:0]]) begin
        found = 1'b1;
        win   = cand[ID_W-1:0];
      end
    end
  end

  // Operand mux and one-hot grant for the winning requester
  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    sel_ctrl = 1'b0;
    gnt_nxt  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == ID_W'(i)) begin
        sel_a      = op_a[16*i +: 16];
        sel_b      = op_b[16*i +: 16];
        sel_ctrl   = op_ctrl[i];
        gnt_nxt[i] = 1'b1;
      end
    end
  end

  sumador_16bits u_sumador (
    .a    (lat_a),
    .b    (lat_b),
    .ctrl (lat_ctrl),
    .sum  (sum)
  );

  // Two-state scheduler: IDLE arbitrates and latches operands, EXEC registers the result
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      lat_id   <= '0;
      lat_a    <= '0;
      lat_b    <= '0;
      lat_ctrl <= 1'b0;
      gnt      <= '0;
      done     <= 1'b0;
      done_id  <= '0;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (found) begin
            lat_id   <= win;
            lat_a    <= sel_a;
            lat_b    <= sel_b;
            lat_ctrl <= sel_ctrl;
            gnt      <= gnt_nxt;
            ptr      <= (win == ID_W'(N_REQ-1)) ? '0 : win + ID_W'(1);
            state    <= EXEC;
          end else begin
            gnt <= '0;
          end
        end
        EXEC: begin
          {overflow, result} <= sum;
          done_id <= lat_id;
          done    <= 1'b1;
          gnt     <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OVF_STICKY_EN
  // Sticky overflow per requester; a set in the same cycle as a clear wins
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_sticky <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (done && overflow && (done_id == ID_W'(i))) ovf_sticky[i] <= 1'b1;
        else if (ovf_clr[i])                            ovf_sticky[i] <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sumador_arbiter.sv
// tb/tb_sumador_arbiter.sv - directed self-checking bench for sumador_arbiter
module tb_sumador_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] op_a;
  logic [63:0] op_b;
  logic [3:0]  op_ctrl;
  logic [3:0]  gnt;
  logic        done;
  logic [1:0]  done_id;
  logic [15:0] result;
  logic        overflow;
`ifdef OVF_STICKY_EN
  logic [3:0]  ovf_clr;
  logic [3:0]  ovf_sticky;
`endif

  int checks;
  int errors;

  logic [3:0]  exp_gnt [5];
  logic [1:0]  exp_id  [5];
  logic [15:0] exp_res [5];

  sumador_arbiter #(.N_REQ(4), .ID_W(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .op_a     (op_a),
    .op_b     (op_b),
    .op_ctrl  (op_ctrl),
    .gnt      (gnt),
    .done     (done),
    .done_id  (done_id),
    .result   (result),
    .overflow (overflow)
`ifdef OVF_STICKY_EN
    ,
    .ovf_clr    (ovf_clr),
    .ovf_sticky (ovf_sticky)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b, input logic c);
    op_a[16*i +: 16] = a;
    op_b[16*i +: 16] = b;
    op_ctrl[i]       = c;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    req = '0;
    op_a = '0;
    op_b = '0;
    op_ctrl = '0;
`ifdef OVF_STICKY_EN
    ovf_clr = '0;
`endif
    tick();
    tick();
    rst = 1'b0;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_done_id", 32'(done_id), 32'h0);
    check("rst_result", 32'(result), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
`ifdef OVF_STICKY_EN
    check("rst_sticky", 32'(ovf_sticky), 32'h0);
`endif

    // Single suma on requester 0
    set_op(0, 16'h1234, 16'h0001, 1'b1);
    req = 4'b0001;
    tick();
    check("t1_gnt", 32'(gnt), 32'h1);
    check("t1_no_done", 32'(done), 32'h0);
    req = '0;
    tick();
    check("t1_done", 32'(done), 32'h1);
    check("t1_gnt_low", 32'(gnt), 32'h0);
    check("t1_result", 32'(result), 32'h1235);
    check("t1_ovf", 32'(overflow), 32'h0);
    check("t1_id", 32'(done_id), 32'h0);
    tick();
    check("t1_done_pulse", 32'(done), 32'h0);
    check("t1_hold", 32'(result), 32'h1235);

    // Carry on requester 1
    set_op(1, 16'hFFFF, 16'h0001, 1'b1);
    req = 4'b0010;
    tick();
    check("t2_gnt", 32'(gnt), 32'h2);
    req = '0;
    tick();
    check("t2_done", 32'(done), 32'h1);
    check("t2_result", 32'(result), 32'h0000);
    check("t2_ovf", 32'(overflow), 32'h1);
    check("t2_id", 32'(done_id), 32'h1);
    // Borrow on requester 1
    set_op(1, 16'h0003, 16'h0005, 1'b0);
    req = 4'b0010;
    tick();
    check("t3_gnt", 32'(gnt), 32'h2);
    req = '0;
    tick();
    check("t3_done", 32'(done), 32'h1);
    check("t3_result", 32'(result), 32'hFFFE);
    check("t3_ovf", 32'(overflow), 32'h1);
    check("t3_id", 32'(done_id), 32'h1);

    // Reset so the rotation starts from requester 0
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Round robin with all requests held
    set_op(0, 16'h1000, 16'h0100, 1'b1);
    set_op(1, 16'h2001, 16'h0100, 1'b0);
    set_op(2, 16'h3002, 16'h0100, 1'b1);
    set_op(3, 16'h4003, 16'h0100, 1'b0);
    exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_res = '{16'h1100, 16'h1F01, 16'h3102, 16'h3F03, 16'h1100};
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("rr%0d_gnt", k), 32'(gnt), 32'(exp_gnt[k]));
      check($sformatf("rr%0d_nodone", k), 32'(done), 32'h0);
      if (k == 4) req = '0;
      tick();
      check($sformatf("rr%0d_done", k), 32'(done), 32'h1);
      check($sformatf("rr%0d_gnt_low", k), 32'(gnt), 32'h0);
      check($sformatf("rr%0d_id", k), 32'(done_id), 32'(exp_id[k]));
      check($sformatf("rr%0d_result", k), 32'(result), 32'(exp_res[k]));
      check($sformatf("rr%0d_ovf", k), 32'(overflow), 32'h0);
    end

    // Rotation skip: grant 2, then only 0 and 2 requesting
    req = 4'b0100;
    tick();
    check("sk_gnt2", 32'(gnt), 32'h4);
    req = 4'b0101;
    tick();
    check("sk_id2", 32'(done_id), 32'h2);
    tick();
    check("sk_gnt0", 32'(gnt), 32'h1);
    req = 4'b0100;
    tick();
    check("sk_id0", 32'(done_id), 32'h0);
    check("sk_res0", 32'(result), 32'h1100);
    tick();
    check("sk_gnt2b", 32'(gnt), 32'h4);
    req = '0;
    tick();
    check("sk_id2b", 32'(done_id), 32'h2);
    check("sk_res2b", 32'(result), 32'h3102);

    // Reset during EXEC after a grant to requester 1 (leaves ptr at 2 if not cleared)
    req = 4'b0010;
    tick();
    check("rx_gnt", 32'(gnt), 32'h2);
    req = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rx_done", 32'(done), 32'h0);
    check("rx_gnt_low", 32'(gnt), 32'h0);
    check("rx_result", 32'(result), 32'h0);
    check("rx_ovf", 32'(overflow), 32'h0);
    check("rx_id", 32'(done_id), 32'h0);
    tick();
    check("rx_no_late_done", 32'(done), 32'h0);
    // ptr back at 0: requesters 1 and 2 pending, 1 wins
    req = 4'b0110;
    tick();
    check("rx_ptr_gnt", 32'(gnt), 32'h2);
    req = '0;
    tick();
    check("rx_ptr_res", 32'(result), 32'h1F01);
    req = 4'b0100;
    tick();
    check("rx_gnt2", 32'(gnt), 32'h4);
    req = '0;
    tick();
    check("rx_id2", 32'(done_id), 32'h2);

`ifdef OVF_STICKY_EN
    // Sticky overflow on requester 3
    set_op(3, 16'hFFFF, 16'h0001, 1'b1);
    req = 4'b1000;
    tick();
    req = '0;
    tick();
    check("st_ovf", 32'(overflow), 32'h1);
    check("st_pre", 32'(ovf_sticky), 32'h0);
    tick();
    check("st_set", 32'(ovf_sticky), 32'h8);
    tick();
    check("st_hold", 32'(ovf_sticky), 32'h8);
    req = 4'b1000;
    tick();
    req = '0;
    tick();
    check("st_ovf2", 32'(overflow), 32'h1);
    ovf_clr = 4'b1000;
    tick();
    ovf_clr = '0;
    check("st_set_wins", 32'(ovf_sticky), 32'h8);
    ovf_clr = 4'b1000;
    tick();
    ovf_clr = '0;
    check("st_clr", 32'(ovf_sticky), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
